// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and types for the HD44780 LCD driver
// Purpose: command bytes, transfer timing, sequencer positions, status codes,
//          FSM state types and small helpers used by lcd_display and
//          lcd_controller.
// Ports:   none (package).
package lcd_pkg;

  // HD44780 commands
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40

  // Transfer timing in 50 MHz clocks
  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_E_WIDTH = 25;
  localparam int unsigned T_HOLD    = 2;
  localparam int unsigned T_DELAY   = 262144;
  localparam int unsigned CNT_W     = 20;  // wide enough for T_DELAY - 1

  // Sequencer positions: 0..4 init, 5..20 line 1, 21 0xC0, 22..37 line 2, 38 0x80
  localparam logic [5:0] POS_INIT_LAST = 6'd4;
  localparam logic [5:0] POS_L1_FIRST  = 6'd5;
  localparam logic [5:0] POS_CMD_L2    = 6'd21;
  localparam logic [5:0] POS_L2_FIRST  = 6'd22;
  localparam logic [5:0] POS_CMD_L1    = 6'd38;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'd0,
    ST_HIT      = 7'd1,
    ST_MISS     = 7'd2,
    ST_GAMEOVER = 7'd3,
    ST_WIN      = 7'd4
  } status_e;

  typedef enum logic [2:0] {
    C_IDLE,
    C_SETUP,
    C_EHIGH,
    C_HOLD,
    C_DELAY,
    C_DONE
  } ctrl_state_e;

  typedef enum logic {
    SEQ_ISSUE,
    SEQ_WAIT
  } seq_state_e;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_FUNC_SET;
      3'd1:    return CMD_DISP_ON;
      3'd2:    return CMD_CLEAR;
      3'd3:    return CMD_ENTRY;
      default: return CMD_LINE1;
    endcase
  endfunction

  // Character idx (0 = leftmost) of a 16-char string packed MSB-first.
  function automatic logic [7:0] char_at(input logic [127:0] s, input logic [3:0] idx);
    return s[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lcd_controller.sv
// rtl/lcd_controller.sv - single HD44780 byte transfer with start/done handshake
// Purpose: latches RS/data on start (only while idle), then drives setup,
//          E-high, hold and inter-transfer delay phases; done pulses for one
//          clock once the delay has elapsed.
// Ports:   clk_i, rst_ni (async active-low); start_i, rs_i, data_i request;
//          done_o completion pulse; lcd_e_o, lcd_rs_o, lcd_data_o to the panel.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = T_DELAY
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             e_q, e_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      e_q     <= e_d;
    end
  end

  // Last count value of each timed phase
  always_comb begin
    limit = '0;
    case (state_q)
      C_SETUP: limit = CNT_W'(T_SETUP - 1);
      C_EHIGH: limit = CNT_W'(T_E_WIDTH - 1);
      C_HOLD:  limit = CNT_W'(T_HOLD - 1);
      C_DELAY: limit = CNT_W'(DELAY_CYCLES - 1);
      default: limit = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_o  = 1'b0;
    case (state_q)
      C_IDLE: begin
        // RS/data stay latched for the whole transfer, so input changes
        // after this point cannot touch the byte in flight.
        if (start_i) begin
          rs_d    = rs_i;
          data_d  = data_i;
          cnt_d   = '0;
          state_d = C_SETUP;
        end
      end
      C_SETUP, C_EHIGH, C_HOLD, C_DELAY: begin
        if (cnt_q == limit) begin
          cnt_d = '0;
          case (state_q)
            C_SETUP: state_d = C_EHIGH;
            C_EHIGH: state_d = C_HOLD;
            C_HOLD:  state_d = C_DELAY;
            default: state_d = C_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      C_DONE: begin
        done_o  = 1'b1;
        state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
    // E is registered from the next state so the strobe is glitch-free.
    e_d = (state_d == C_EHIGH);
  end

  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_display.sv
// rtl/lcd_display.sv - game status display on a 16x2 HD44780 LCD
// Purpose: init/line sequencer plus character ROM/mux; each byte is handed to
//          lcd_controller and the two lines are refreshed forever.
// Ports:   iCLK_50MHZ, iRST_N (async active-low); lcd0 status code; lcd6/lcd7
//          ASCII hit digits; cont_a hits, cont_e errors; lcd1..3, botoes
//          reserved; DATA_BUS, LCD_RW, LCD_E, LCD_RS to the panel.
module lcd_display
  import lcd_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = T_DELAY
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic [6:0] lcd0,
  input  logic [6:0] lcd1,
  input  logic [6:0] lcd2,
  input  logic [6:0] lcd3,
  input  logic [6:0] lcd6,
  input  logic [6:0] lcd7,
  input  logic [7:0] cont_a,
  input  logic [7:0] cont_e,
  input  logic [3:0] botoes,
  inout  wire  [7:0] DATA_BUS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_RS
);

  localparam logic [127:0] MSG_IDLE = "MOLES ATTACK    ";
  localparam logic [127:0] MSG_HIT  = "HIT!            ";
  localparam logic [127:0] MSG_MISS = "MISS!           ";
  localparam logic [127:0] MSG_OVER = "GAME OVER       ";
  localparam logic [127:0] MSG_WIN  = "YOU WIN!        ";

  seq_state_e   seq_q, seq_d;
  logic [5:0]   pos_q, pos_d;
  logic         start;
  logic         ctrl_done;
  logic         xfer_rs;
  logic [7:0]   xfer_data;
  logic [127:0] line1_text;
  logic [127:0] line2_text;
  logic [7:0]   e_char;
  logic [7:0]   hit_div;
  logic [7:0]   v_char;
  logic [7:0]   bus_data;
  logic         unused_inputs;

  assign unused_inputs = ^{lcd1, lcd2, lcd3, botoes};

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      seq_q <= SEQ_ISSUE;
      pos_q <= '0;
    end else begin
      seq_q <= seq_d;
      pos_q <= pos_d;
    end
  end

  // Controller is always idle in SEQ_ISSUE (it returns to idle right after done).
  always_comb begin
    seq_d = seq_q;
    pos_d = pos_q;
    start = 1'b0;
    case (seq_q)
      SEQ_ISSUE: begin
        start = 1'b1;
        seq_d = SEQ_WAIT;
      end
      default: begin
        if (ctrl_done) begin
          seq_d = SEQ_ISSUE;
          pos_d = (pos_q == POS_CMD_L1) ? POS_L1_FIRST : pos_q + 6'd1;
        end
      end
    endcase
  end

  always_comb begin
    line1_text = MSG_IDLE;
    case (lcd0)
      ST_HIT:      line1_text = MSG_HIT;
      ST_MISS:     line1_text = MSG_MISS;
      ST_GAMEOVER: line1_text = MSG_OVER;
      ST_WIN:      line1_text = MSG_WIN;
      default:     line1_text = MSG_IDLE;
    endcase
  end

  // Error digit saturates at 9; level is hits/5 + 1 capped at 4.
  assign e_char  = (cont_e > 8'd9) ? 8'h39 : 8'h30 + cont_e;
  assign hit_div = cont_a / 8'd5;
  assign v_char  = (hit_div >= 8'd3) ? 8'h34 : 8'h31 + hit_div;

  assign line2_text = {"HIT:", 1'b0, lcd6, 1'b0, lcd7, " ERR:", e_char, " L", v_char, " "};

  // Inputs are read combinationally here, i.e. at the moment the byte is fetched.
  always_comb begin
    xfer_rs   = 1'b0;
    xfer_data = 8'h00;
    if (pos_q <= POS_INIT_LAST) begin
      xfer_data = init_cmd(pos_q[2:0]);
    end else if (pos_q < POS_CMD_L2) begin
      xfer_rs   = 1'b1;
      xfer_data = char_at(line1_text, 4'(pos_q - POS_L1_FIRST));
    end else if (pos_q == POS_CMD_L2) begin
      xfer_data = CMD_LINE2;
    end else if (pos_q < POS_CMD_L1) begin
      xfer_rs   = 1'b1;
      xfer_data = char_at(line2_text, 4'(pos_q - POS_L2_FIRST));
    end else begin
      xfer_data = CMD_LINE1;
    end
  end

  lcd_controller #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_ctrl (
    .clk_i     (iCLK_50MHZ),
    .rst_ni    (iRST_N),
    .start_i   (start),
    .rs_i      (xfer_rs),
    .data_i    (xfer_data),
    .done_o    (ctrl_done),
    .lcd_e_o   (LCD_E),
    .lcd_rs_o  (LCD_RS),
    .lcd_data_o(bus_data)
  );

  // Write-only panel: the bus is never released.
  assign DATA_BUS = bus_data;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_display.sv
// tb/tb_lcd_display.sv - self-checking bench for lcd_display
module tb_lcd_display;

  localparam int unsigned DELAY = 40;

  logic       clk = 1'b0;
  logic       iRST_N;
  logic [6:0] lcd0, lcd1, lcd2, lcd3, lcd6, lcd7;
  logic [7:0] cont_a, cont_e;
  logic [3:0] botoes;
  wire  [7:0] DATA_BUS;
  logic       LCD_RW, LCD_E, LCD_RS;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  lcd_display #(.DELAY_CYCLES(DELAY)) dut (
    .iCLK_50MHZ(clk),
    .iRST_N    (iRST_N),
    .lcd0      (lcd0),
    .lcd1      (lcd1),
    .lcd2      (lcd2),
    .lcd3      (lcd3),
    .lcd6      (lcd6),
    .lcd7      (lcd7),
    .cont_a    (cont_a),
    .cont_e    (cont_e),
    .botoes    (botoes),
    .DATA_BUS  (DATA_BUS),
    .LCD_RW    (LCD_RW),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    int         gap;
    bit         first;
    bit         setup_ok;
    bit         hold_ok;
  } xfer_t;

  xfer_t xq[$];

  // Transfer monitor: E width in clocks, E-low gap, setup/hold stability
  xfer_t      cur;
  logic       e_prev, in_high, hold_pend, have_fall;
  logic       rs_h1, rs_h2;
  logic [7:0] d_h1, d_h2;
  int         since_fall;

  function automatic xfer_t close_xfer(input xfer_t x, input bit ok);
    xfer_t r;
    r = x;
    r.hold_ok = x.hold_ok && ok;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!iRST_N) begin
      e_prev <= 1'b0; in_high <= 1'b0; hold_pend <= 1'b0; have_fall <= 1'b0;
      rs_h1 <= 1'b0; rs_h2 <= 1'b0; d_h1 <= 8'h00; d_h2 <= 8'h00; since_fall <= 0;
    end else begin
      if (LCD_E && !e_prev) begin
        cur.rs       <= LCD_RS;
        cur.data     <= DATA_BUS;
        cur.width    <= 1;
        cur.gap      <= since_fall;
        cur.first    <= !have_fall;
        cur.setup_ok <= (d_h1 === DATA_BUS) && (d_h2 === DATA_BUS) && (rs_h1 === LCD_RS) && (rs_h2 === LCD_RS);
        cur.hold_ok  <= 1'b1;
        in_high      <= 1'b1;
      end else if (LCD_E && in_high) begin
        cur.width <= cur.width + 1;
        if (DATA_BUS !== cur.data || LCD_RS !== cur.rs) cur.hold_ok <= 1'b0;
      end else if (!LCD_E && in_high) begin
        in_high    <= 1'b0;
        hold_pend  <= 1'b1;
        have_fall  <= 1'b1;
        since_fall <= 1;
        if (DATA_BUS !== cur.data || LCD_RS !== cur.rs) cur.hold_ok <= 1'b0;
      end else begin
        since_fall <= since_fall + 1;
        if (hold_pend) begin
          hold_pend <= 1'b0;
          xq.push_back(close_xfer(cur, (DATA_BUS === cur.data) && (LCD_RS === cur.rs)));
        end
      end
      e_prev <= LCD_E;
      rs_h2 <= rs_h1; rs_h1 <= LCD_RS;
      d_h2  <= d_h1;  d_h1  <= DATA_BUS;
    end
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_xfer(input string tag, input logic exp_rs, input logic [7:0] exp_data);
    xfer_t x;
    bit    got;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (xq.size() > 0) begin
        x   = xq.pop_front();
        got = 1'b1;
      end
    end
    n_tests++;
    assert (got) else begin
      n_fail++;
      $error("FAIL %s: no transfer within 1000 clocks, expected rs=%0b data=%02h", tag, exp_rs, exp_data);
    end
    if (got) begin
      n_tests++;
      assert (x.rs === exp_rs && x.data === exp_data) else begin
        n_fail++;
        $error("FAIL %s: rs/data %0b/%02h expected %0b/%02h", tag, x.rs, x.data, exp_rs, exp_data);
      end
      n_tests++;
      assert (x.width == 25 && x.setup_ok && x.hold_ok) else begin
        n_fail++;
        $error("FAIL %s_timing: width=%0d setup=%0b hold=%0b expected 25/1/1", tag, x.width, x.setup_ok, x.hold_ok);
      end
      n_tests++;
      assert (x.first || x.gap >= int'(DELAY)) else begin
        n_fail++;
        $error("FAIL %s_gap: gap=%0d expected >= %0d", tag, x.gap, DELAY);
      end
    end
  endtask

  task automatic check_init();
    logic [7:0] cmds [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    for (int i = 0; i < 5; i++) check_xfer($sformatf("init%0d", i), 1'b0, cmds[i]);
  endtask

  task automatic check_line(input string tag, input logic [127:0] s, input int from, input int to);
    for (int i = from; i <= to; i++)
      check_xfer($sformatf("%s_c%0d", tag, i), 1'b1, s[8*(15-i) +: 8]);
  endtask

  task automatic wait_e_high(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (LCD_E === 1'b1);
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL %s: LCD_E never rose, got 0 expected 1", tag);
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    lcd0 = 7'd0; lcd1 = 7'd0; lcd2 = 7'd0; lcd3 = 7'd0;
    lcd6 = 7'h30; lcd7 = 7'h30; cont_a = 8'd0; cont_e = 8'd0; botoes = 4'd0;
    repeat (3) @(negedge clk);
    chk8("rst_e",    {7'd0, LCD_E},  8'h00);
    chk8("rst_rs",   {7'd0, LCD_RS}, 8'h00);
    chk8("rst_rw",   {7'd0, LCD_RW}, 8'h00);
    chk8("rst_data", DATA_BUS,       8'h00);
    iRST_N = 1'b1;

    // Pass A: idle text, zero counts
    check_init();
    check_line("a_l1", "MOLES ATTACK    ", 0, 15);
    check_xfer("a_c0", 1'b0, 8'hC0);
    check_line("a_l2", "HIT:00 ERR:0 L1 ", 0, 15);
    check_xfer("a_80", 1'b0, 8'h80);

    // Pass B: win, level capped at 4; reserved inputs toggled
    lcd0 = 7'd4; lcd6 = 7'h32; lcd7 = 7'h30; cont_a = 8'd20; cont_e = 8'd2;
    lcd1 = 7'h55; lcd2 = 7'h2A; lcd3 = 7'h7F; botoes = 4'hA;
    check_line("b_l1", "YOU WIN!        ", 0, 15);
    check_xfer("b_c0", 1'b0, 8'hC0);
    check_line("b_l2", "HIT:20 ERR:2 L4 ", 0, 15);
    check_xfer("b_80", 1'b0, 8'h80);

    // Pass C: error digit saturates, cont_e changed while its byte is in flight
    lcd0 = 7'd2; lcd6 = 7'h30; lcd7 = 7'h37; cont_a = 8'd7; cont_e = 8'd12;
    lcd1 = 7'h00; botoes = 4'h5;
    check_line("c_l1", "MISS!           ", 0, 15);
    check_xfer("c_c0", 1'b0, 8'hC0);
    check_line("c_l2", "HIT:07 ERR:9 L2 ", 0, 10);
    wait_e_high("c_inflight_e");
    cont_e = 8'd0;
    check_line("c_l2", "HIT:07 ERR:9 L2 ", 11, 15);
    check_xfer("c_80", 1'b0, 8'h80);

    // Pass D: game over, reset asserted mid line 2
    lcd0 = 7'd3;
    check_line("d_l1", "GAME OVER       ", 0, 15);
    check_xfer("d_c0", 1'b0, 8'hC0);
    check_line("d_l2", "HIT:07 ERR:0 L2 ", 0, 5);
    wait_e_high("d_inflight_e");
    repeat (3) @(negedge clk);
    iRST_N = 1'b0;
    #1;
    chk8("mid_rst_e",    {7'd0, LCD_E},  8'h00);
    chk8("mid_rst_rs",   {7'd0, LCD_RS}, 8'h00);
    chk8("mid_rst_rw",   {7'd0, LCD_RW}, 8'h00);
    chk8("mid_rst_data", DATA_BUS,       8'h00);
    repeat (4) @(negedge clk);
    xq.delete();
    lcd0 = 7'd100;
    iRST_N = 1'b1;

    // Restart: full init again, out-of-range status shows idle text
    check_init();
    check_line("e_l1", "MOLES ATTACK    ", 0, 15);
    lcd0 = 7'd1;
    check_xfer("e_c0", 1'b0, 8'hC0);
    check_line("e_l2", "HIT:07 ERR:0 L2 ", 0, 15);
    check_xfer("e_80", 1'b0, 8'h80);
    check_line("f_l1", "HIT!            ", 0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
